// File: rtl/mul8_seq_ctrl.sv
// Unsigned 8x8->16 multiply, one shared 4x4 array core, one nibble cross-product per cycle.
// Latency: result valid 4 cycles after accept (1 cycle for zero operands with MUL8_SEQ_ZERO_SKIP_EN).
// Backpressure: DONE holds p/out_valid until out_ready; in_ready only in IDLE.

module tt_um_array_multiplier_hhrb98 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] row [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            row[i] = b[i] ? ({4'b0, a} << i) : 8'h00;
        end
        p = row[0] + row[1] + row[2] + row[3];
    end
endmodule

module mul8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc;
    logic [3:0]  core_a, core_b;
    logic [7:0]  core_p;
    logic [15:0] pp_sh;
    logic        zero_op;

    tt_um_array_multiplier_hhrb98 u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    // Step order: aL*bL, aH*bL, aL*bH, aH*bH
    always_comb begin
        core_a = step[0] ? a_q[7:4] : a_q[3:0];
        core_b = step[1] ? b_q[7:4] : b_q[3:0];
        case (step)
            2'd0:    pp_sh = {8'h00, core_p};
            2'd3:    pp_sh = {core_p, 8'h00};
            default: pp_sh = {4'h0, core_p, 4'h0};
        endcase
    end

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    assign zero_op = (a_q == 8'h00) || (b_q == 8'h00);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL;
            MUL:     if (zero_op || step == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= 2'd0;
            acc  <= 16'h0000;
            p    <= 16'h0000;
            a_q  <= 8'h00;
            b_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= 16'h0000;
                        step <= 2'd0;
                    end
                end
                MUL: begin
                    if (zero_op) begin
                        p <= 16'h0000;
                    end else begin
                        acc  <= acc + pp_sh;
                        step <= step + 2'd1;
                        if (step == 2'd3) p <= acc + pp_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and randomized checks of mul8_seq_ctrl against hand-computed and reference products.
module tb_mul8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 4;
`endif

    mul8_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for idle, presents operands, returns just after the accept edge.
    task automatic accept_op(input logic [7:0] va, input logic [7:0] vb, output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic [15:0] exp, input int exp_lat);
        int ac, lat;
        accept_op(va, vb, ac);
        chk({tag, "_rdy_busy"}, 32'({in_ready, busy}), 32'b01);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_p"}, 32'(p), 32'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_post"}, 32'({out_valid, in_ready, busy}), 32'b010);
        chk({tag, "_hold"}, 32'(p), 32'(exp));
    endtask

    initial begin
        int ac, lat, last, guard;
        logic [7:0]  ra, rb;
        logic [15:0] rexp;
        logic        seen_v;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 32'({in_ready, out_valid, busy, p}), 32'({1'b1, 1'b0, 1'b0, 16'h0000}));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("single", 8'h12, 8'h34, 16'h03A8, 4);
        run_op("ffff", 8'hFF, 8'hFF, 16'hFE01, 4);
        run_op("ff01", 8'hFF, 8'h01, 16'h00FF, 4);

        // Backpressure with a competing in_valid held through the result handshake
        out_ready = 1'b0;
        accept_op(8'hA5, 8'h3C, ac);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        @(negedge clk);
        in_valid = 1'b1; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 32'({out_valid, in_ready, busy, p}), 32'({3'b101, 16'h26AC}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'({out_valid, in_ready, busy, p}), 32'({3'b010, 16'h26AC}));
        in_valid = 1'b0;

        // Reset during step 2
        accept_op(8'h55, 8'h66, ac);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid", 32'({out_valid, in_ready, busy, p}), 32'({3'b010, 16'h0000}));
        @(negedge clk);
        rst_n = 1'b1;
        seen_v = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_v = 1'b1;
        end
        chk("rst_no_stale", 32'(seen_v), 32'd0);
        run_op("after_rst", 8'h07, 8'h09, 16'h003F, 4);

        run_op("zero", 8'h00, 8'hAB, 16'h0000, ZLAT);

        // Random back-to-back with random consumer stalls
        last = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rexp = 16'(ra) * 16'(rb);
            accept_op(ra, rb, ac);
            if (i > 0) chk("rnd_spacing", 32'((ac - last) >= 6), 32'd1);
            last = ac;
            guard = 0;
            forever begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                guard++;
                if (out_valid && out_ready) begin
                    chk("rnd_p", 32'(p), 32'(rexp));
                    @(posedge clk);
                    break;
                end
                if (guard > 200) begin
                    chk("rnd_hs_timeout", 32'(out_valid), 32'd1);
                    break;
                end
            end
        end
        out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
